// File: rtl/lc3b_cache_control.sv
// LC-3b L1 cache controller: hit/miss decode, writeback and line-fill sequencing.
// Optional perf counters (hit/miss/writeback) enabled by CACHE_PERF_CNT_EN.
package lc3b_ctypes;

  typedef enum logic {
    inmux_cdata = 1'b0,
    inmux_pmem  = 1'b1
  } lc3b_cache_inmux_sel;

  typedef enum logic [1:0] {
    addrmux_mem_address = 2'd0,
    addrmux_0           = 2'd1,
    addrmux_tag0        = 2'd2,
    addrmux_tag1        = 2'd3
  } lc3b_caddrmux_sel;

endpackage

module lc3b_cache_control
  import lc3b_ctypes::*;
#(
  parameter int CNT_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                mem_read,
  input  logic                mem_write,
  output logic                mem_resp,
  input  logic                hit0,
  input  logic                hit1,
  input  logic                dirty0,
  input  logic                dirty1,
  input  logic                lru,
  output logic                pmem_read,
  output logic                pmem_write,
  input  logic                pmem_resp,
  output logic                load_data0,
  output logic                load_data1,
  output logic                load_tag0,
  output logic                load_tag1,
  output logic                load_valid0,
  output logic                load_valid1,
  output logic                load_dirty0,
  output logic                load_dirty1,
  output logic                dirty_in,
  output logic                load_lru,
  output logic                lru_in,
  output lc3b_cache_inmux_sel inmux_sel,
  output lc3b_caddrmux_sel    addrmux_sel
`ifdef CACHE_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] hit_count,
  output logic [CNT_WIDTH-1:0] miss_count,
  output logic [CNT_WIDTH-1:0] wb_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_t;

  state_t state, state_n;
  logic   victim;
  logic   req, hit, hitway;
  logic   hit_ev, miss_ev, wb_ev;

  assign req     = mem_read | mem_write;
  assign hit     = hit0 | hit1;
  assign hitway  = ~hit0;
  assign hit_ev  = rst_n & (state == IDLE) & req & hit;
  assign miss_ev = rst_n & (state == IDLE) & req & ~hit;
  assign wb_ev   = rst_n & (state == WRITEBACK) & pmem_resp;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      victim <= 1'b0;
    end else begin
      state <= state_n;
      if (miss_ev) victim <= lru;
    end
  end

  always_comb begin
    state_n     = state;
    mem_resp    = 1'b0;
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    load_data0  = 1'b0;
    load_data1  = 1'b0;
    load_tag0   = 1'b0;
    load_tag1   = 1'b0;
    load_valid0 = 1'b0;
    load_valid1 = 1'b0;
    load_dirty0 = 1'b0;
    load_dirty1 = 1'b0;
    dirty_in    = 1'b0;
    load_lru    = 1'b0;
    lru_in      = 1'b0;
    inmux_sel   = inmux_cdata;
    addrmux_sel = addrmux_mem_address;
    // Held in reset: no array writes even if pmem_resp lands now
    if (rst_n) begin
      unique case (state)
        IDLE: begin
          if (req && hit) begin
            mem_resp = 1'b1;
            load_lru = 1'b1;
            lru_in   = ~hitway;
            if (mem_write) begin
              load_data0  = ~hitway;
              load_data1  = hitway;
              load_dirty0 = ~hitway;
              load_dirty1 = hitway;
              dirty_in    = 1'b1;
            end
          end else if (req) begin
            state_n = (lru ? dirty1 : dirty0) ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          pmem_write  = 1'b1;
          addrmux_sel = victim ? addrmux_tag1 : addrmux_tag0;
          if (pmem_resp) state_n = ALLOCATE;
        end
        ALLOCATE: begin
          pmem_read   = 1'b1;
          addrmux_sel = addrmux_0;
          if (pmem_resp) begin
            inmux_sel   = inmux_pmem;
            load_data0  = ~victim;
            load_data1  = victim;
            load_tag0   = ~victim;
            load_tag1   = victim;
            load_valid0 = ~victim;
            load_valid1 = victim;
            load_dirty0 = ~victim;
            load_dirty1 = victim;
            state_n     = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

`ifdef CACHE_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
      wb_count   <= '0;
    end else begin
      if (hit_ev && hit_count != '1)
        hit_count <= hit_count + 1'b1;
      if (miss_ev && miss_count != '1)
        miss_count <= miss_count + 1'b1;
      if (wb_ev && wb_count != '1)
        wb_count <= wb_count + 1'b1;
    end
  end
`else
  logic unused_ev;
  assign unused_ev = hit_ev ^ wb_ev;
`endif

endmodule

// File: tb/tb_lc3b_cache_control.sv
// Self-checking bench for lc3b_cache_control: per-cycle expected
// control vectors queued at drive time, popped and compared mid-cycle.
module tb_lc3b_cache_control;
  import lc3b_ctypes::*;

  logic clk = 1'b0;
  logic rst_n, mem_read, mem_write, mem_resp;
  logic hit0, hit1, dirty0, dirty1, lru;
  logic pmem_read, pmem_write, pmem_resp;
  logic load_data0, load_data1, load_tag0, load_tag1;
  logic load_valid0, load_valid1, load_dirty0, load_dirty1;
  logic dirty_in, load_lru, lru_in;
  lc3b_cache_inmux_sel inmux_sel;
  lc3b_caddrmux_sel    addrmux_sel;
`ifdef CACHE_PERF_CNT_EN
  logic [3:0] hit_count, miss_count, wb_count;
`endif

  always #5 clk = ~clk;

`ifdef CACHE_PERF_CNT_EN
  lc3b_cache_control #(.CNT_WIDTH(4)) dut (
`else
  lc3b_cache_control dut (
`endif
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_resp(mem_resp),
    .hit0(hit0), .hit1(hit1),
    .dirty0(dirty0), .dirty1(dirty1), .lru(lru),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_resp(pmem_resp),
    .load_data0(load_data0), .load_data1(load_data1),
    .load_tag0(load_tag0), .load_tag1(load_tag1),
    .load_valid0(load_valid0), .load_valid1(load_valid1),
    .load_dirty0(load_dirty0), .load_dirty1(load_dirty1),
    .dirty_in(dirty_in), .load_lru(load_lru), .lru_in(lru_in),
    .inmux_sel(inmux_sel), .addrmux_sel(addrmux_sel)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count(hit_count), .miss_count(miss_count),
    .wb_count(wb_count)
`endif
  );

  typedef struct packed {
    logic rst, rd, wr, h0, h1, d0, d1, lr, pr;
  } in_t;

  typedef struct packed {
    logic resp, pr, pw;
    logic ld0, ld1, lt0, lt1, lv0, lv1;
    logic ldd0, ldd1, din, llru, lin;
    lc3b_cache_inmux_sel inmux;
    lc3b_caddrmux_sel    addr;
  } o_t;

  int  n_cmp = 0;
  int  n_err = 0;
  o_t  sb[$];
  in_t si[$];

  function automatic in_t mk(logic rd, logic wr, logic h0,
                             logic h1, logic d0, logic d1,
                             logic lr, logic pr, logic rst = 0);
    in_t v;
    v = '{rst, rd, wr, h0, h1, d0, d1, lr, pr};
    return v;
  endfunction

  function automatic o_t o_none();
    o_t o;
    o = '0;
    o.inmux = inmux_cdata;
    o.addr  = addrmux_mem_address;
    return o;
  endfunction

  function automatic o_t o_rhit(logic w);
    o_t o;
    o = o_none();
    o.resp = 1; o.llru = 1; o.lin = ~w;
    return o;
  endfunction

  function automatic o_t o_whit(logic w);
    o_t o;
    o = o_rhit(w);
    o.ld0 = ~w; o.ld1 = w;
    o.ldd0 = ~w; o.ldd1 = w;
    o.din = 1;
    return o;
  endfunction

  function automatic o_t o_alloc();
    o_t o;
    o = o_none();
    o.pr = 1; o.addr = addrmux_0;
    return o;
  endfunction

  function automatic o_t o_fill(logic w);
    o_t o;
    o = o_alloc();
    o.inmux = inmux_pmem;
    o.ld0 = ~w; o.ld1 = w;
    o.lt0 = ~w; o.lt1 = w;
    o.lv0 = ~w; o.lv1 = w;
    o.ldd0 = ~w; o.ldd1 = w;
    return o;
  endfunction

  function automatic o_t o_wb(logic w);
    o_t o;
    o = o_none();
    o.pw = 1;
    o.addr = w ? addrmux_tag1 : addrmux_tag0;
    return o;
  endfunction

  function automatic o_t sample();
    o_t o;
    o.resp = mem_resp; o.pr = pmem_read; o.pw = pmem_write;
    o.ld0 = load_data0; o.ld1 = load_data1;
    o.lt0 = load_tag0; o.lt1 = load_tag1;
    o.lv0 = load_valid0; o.lv1 = load_valid1;
    o.ldd0 = load_dirty0; o.ldd1 = load_dirty1;
    o.din = dirty_in; o.llru = load_lru; o.lin = lru_in;
    o.inmux = inmux_sel; o.addr = addrmux_sel;
    return o;
  endfunction

  task automatic drive(in_t v);
    rst_n = ~v.rst; mem_read = v.rd; mem_write = v.wr;
    hit0 = v.h0; hit1 = v.h1; dirty0 = v.d0; dirty1 = v.d1;
    lru = v.lr; pmem_resp = v.pr;
  endtask

  task automatic add(in_t v, o_t e);
    si.push_back(v);
    sb.push_back(e);
  endtask

  task automatic test_reset();
    o_t got, exp;
    in_t v;
    add(mk(1,0,1,0,0,0,0,0,1), o_none());
    add(mk(0,0,0,0,0,0,0,0,1), o_none());
    add(mk(0,0,0,0,0,0,0,0), o_none());
    while (si.size() > 0) begin
      v = si.pop_front();
      drive(v);
      #2;
      got = sample();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL reset: got %h want %h", got, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_cold_read();
    o_t got, exp;
    in_t v;
    int cyc = 0;
    add(mk(1,0,0,0,0,0,0,0), o_none());
    add(mk(1,0,0,0,0,0,1,0), o_alloc());
    add(mk(1,0,0,0,0,0,1,1), o_fill(0));
    add(mk(1,0,1,0,0,0,0,0), o_rhit(0));
    add(mk(0,0,0,0,0,0,0,0), o_none());
    while (si.size() > 0) begin
      v = si.pop_front();
      drive(v);
      #2;
      got = sample();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp || (pmem_read && pmem_write)) begin
        n_err++;
        $display("FAIL cold_read c%0d: got %h want %h",
                 cyc, got, exp);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_hits();
    o_t got, exp;
    in_t v;
    int cyc = 0;
    add(mk(1,0,1,0,0,0,0,0), o_rhit(0));
    add(mk(0,0,0,0,0,0,0,0), o_none());
    add(mk(0,1,0,1,0,0,0,0), o_whit(1));
    add(mk(0,0,0,0,0,0,0,0), o_none());
    add(mk(1,1,1,1,0,0,0,0), o_whit(0));
    add(mk(1,0,1,1,0,0,1,0), o_rhit(0));
    add(mk(0,0,0,0,0,0,0,0), o_none());
    while (si.size() > 0) begin
      v = si.pop_front();
      drive(v);
      #2;
      got = sample();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL hits c%0d: got %h want %h",
                 cyc, got, exp);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic queue_writeback();
    add(mk(1,0,0,0,0,1,1,0), o_none());
    for (int i = 0; i < 4; i++)
      add(mk(1,0,0,0,0,0,0,0), o_wb(1));
    add(mk(1,0,0,0,0,0,0,1), o_wb(1));
    add(mk(1,0,0,0,0,0,0,0), o_alloc());
    add(mk(1,0,0,0,0,0,0,1), o_fill(1));
    add(mk(1,0,0,1,0,0,0,0), o_rhit(1));
    add(mk(0,0,0,0,0,0,0,0), o_none());
  endtask

  task automatic test_writeback();
    o_t got, exp;
    in_t v;
    int cyc = 0;
    queue_writeback();
    add(mk(1,0,0,0,1,0,1,0), o_none());
    add(mk(1,0,0,0,1,0,0,0), o_alloc());
    add(mk(1,0,0,0,1,0,0,1), o_fill(1));
    add(mk(0,0,0,0,0,0,0,0), o_none());
    while (si.size() > 0) begin
      v = si.pop_front();
      drive(v);
      #2;
      got = sample();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp || (pmem_read && pmem_write)) begin
        n_err++;
        $display("FAIL writeback c%0d: got %h want %h",
                 cyc, got, exp);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_drop_and_reset();
    o_t got, exp;
    in_t v;
    int cyc = 0;
    add(mk(1,0,0,0,0,0,0,0), o_none());
    add(mk(0,0,0,0,0,0,1,0), o_alloc());
    add(mk(0,0,0,0,0,0,1,1), o_fill(0));
    add(mk(0,0,0,0,0,0,0,0), o_none());
    add(mk(1,0,0,0,0,0,0,0), o_none());
    add(mk(1,0,0,0,0,0,0,0), o_alloc());
    add(mk(1,0,0,0,0,0,0,1,1), o_none());
    add(mk(0,0,0,0,0,0,0,1), o_none());
    add(mk(0,1,0,0,0,1,1,0), o_none());
    add(mk(0,1,0,0,0,0,0,0), o_wb(1));
    add(mk(0,1,0,0,0,0,0,0,1), o_none());
    add(mk(0,0,0,0,0,0,0,1), o_none());
    while (si.size() > 0) begin
      v = si.pop_front();
      drive(v);
      #2;
      got = sample();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL drop_reset c%0d: got %h want %h",
                 cyc, got, exp);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    o_t got, exp;
    in_t v;
    int cyc = 0;
    add(mk(1,0,1,0,0,0,0,0), o_rhit(0));
    add(mk(1,0,0,1,0,0,0,0), o_rhit(1));
    add(mk(0,1,1,0,0,0,1,0), o_whit(0));
    add(mk(0,1,0,1,1,1,0,0), o_whit(1));
    add(mk(1,0,1,0,1,1,1,0), o_rhit(0));
    add(mk(0,0,0,0,0,0,0,0), o_none());
    while (si.size() > 0) begin
      v = si.pop_front();
      drive(v);
      #2;
      got = sample();
      exp = sb.pop_front();
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL back_to_back c%0d: got %h want %h",
                 cyc, got, exp);
      end
      cyc++;
      @(negedge clk);
    end
  endtask

`ifdef CACHE_PERF_CNT_EN
  task automatic test_perf();
    in_t v;
    logic [11:0] exp_c;
    add(mk(0,0,0,0,0,0,0,0,1), o_none());
    queue_writeback();
    while (si.size() > 0) begin
      v = si.pop_front();
      void'(sb.pop_front());
      drive(v);
      @(negedge clk);
    end
    exp_c = {4'd1, 4'd1, 4'd1};
    n_cmp++;
    if ({hit_count, miss_count, wb_count} !== exp_c) begin
      n_err++;
      $display("FAIL perf_wb: got %h want %h",
               {hit_count, miss_count, wb_count}, exp_c);
    end
    for (int i = 0; i < 20; i++) begin
      drive(mk(1,0,1,0,0,0,0,0));
      @(negedge clk);
    end
    drive(mk(0,0,0,0,0,0,0,0));
    @(negedge clk);
    exp_c = {4'hF, 4'd1, 4'd1};
    n_cmp++;
    if ({hit_count, miss_count, wb_count} !== exp_c) begin
      n_err++;
      $display("FAIL perf_sat: got %h want %h",
               {hit_count, miss_count, wb_count}, exp_c);
    end
  endtask
`endif

  initial begin
    drive(mk(0,0,0,0,0,0,0,0,1));
    @(negedge clk);
    test_reset();
    test_cold_read();
    test_hits();
    test_writeback();
    test_drop_and_reset();
    test_back_to_back();
`ifdef CACHE_PERF_CNT_EN
    test_perf();
`endif
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard: %0d left, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
